// File: rtl/disc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : disc_sched_pkg
// Description : Shared types and constants for the discriminator scheduler.
//               Holds the FSM state encoding, the source identifiers, the
//               Q1.15 decision threshold, the image geometry and the
//               probability clamp helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package disc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic SRC_REAL = 1'b0;
  localparam logic SRC_FAKE = 1'b1;

  localparam logic [15:0] HALF_Q15 = 16'h4000;

  localparam int PIX_W = 16;
  localparam int NPIX  = 9;
  localparam int IMG_W = PIX_W * NPIX;

  // A probability below zero is meaningless; pin it to 0.0.
  function automatic logic [PIX_W-1:0] clamp_q15(input logic [PIX_W-1:0] v);
    return v[PIX_W-1] ? '0 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter between the real and the fake
//               sample requester. Grants combinationally while enabled and
//               remembers the last granted source on each accept.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               en             - arbitration allowed this cycle
//               req_real/fake  - request lines
//               accept         - the granted request was taken this cycle
//               gnt_real/fake  - one-hot (or zero) grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import disc_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_real,
  input  logic req_fake,
  input  logic accept,
  output logic gnt_real,
  output logic gnt_fake
);

  logic last_grant;

  always_comb begin
    gnt_real = 1'b0;
    gnt_fake = 1'b0;
    if (en) begin
      if (req_real && req_fake) begin
        // Contention: hand the slot to whoever did not get it last time.
        if (last_grant == SRC_FAKE) gnt_real = 1'b1;
        else                        gnt_fake = 1'b1;
      end else begin
        gnt_real = req_real;
        gnt_fake = req_fake;
      end
    end
  end

  // Resetting to "fake" makes real win the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_FAKE;
    end else if (accept) begin
      last_grant <= gnt_fake ? SRC_FAKE : SRC_REAL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/disc_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : disc_scheduler
// Description : Time-shares one combinational discriminator between a real
//               and a generator (fake) sample stream. One request in flight;
//               the image is registered onto disc_img, the probability is
//               captured after SETTLE_CYCLES, clamped, and returned on a
//               valid/ready response port. Keeps saturating statistics.
// Ports       : clk, rst_n                    - clock, async active-low reset
//               real_valid/ready/pix          - real sample request
//               fake_valid/ready/pix          - fake sample request
//               disc_img, disc_prob           - discriminator image / result
//               rsp_valid/ready/prob/src/is_real - response channel
//               clr_stats                     - synchronous statistics clear
//               cnt_real/fake/fooled          - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module disc_scheduler
  import disc_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             real_valid,
  output logic             real_ready,
  input  logic [IMG_W-1:0] real_pix,
  input  logic             fake_valid,
  output logic             fake_ready,
  input  logic [IMG_W-1:0] fake_pix,
  output logic [IMG_W-1:0] disc_img,
  input  logic [PIX_W-1:0] disc_prob,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [PIX_W-1:0] rsp_prob,
  output logic             rsp_src,
  output logic             rsp_is_real,
  input  logic             clr_stats,
  output logic [15:0]      cnt_real,
  output logic [15:0]      cnt_fake,
  output logic [15:0]      cnt_fooled
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       gnt_real;
  logic       gnt_fake;
  logic       accept;
  logic       capture;
  logic       rsp_hs;

  // Readies are also held low while reset is asserted.
  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (rst_n && (state == ST_IDLE)),
    .req_real (real_valid),
    .req_fake (fake_valid),
    .accept   (accept),
    .gnt_real (gnt_real),
    .gnt_fake (gnt_fake)
  );

  assign real_ready  = gnt_real;
  assign fake_ready  = gnt_fake;
  assign accept      = (real_valid && gnt_real) || (fake_valid && gnt_fake);
  assign capture     = (state == ST_EVAL) && (settle_cnt == SETTLE_LAST);
  assign rsp_hs      = rsp_valid && rsp_ready;
  assign rsp_is_real = (rsp_prob >= HALF_Q15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)  state_nxt = ST_EVAL;
      ST_EVAL: if (capture) state_nxt = ST_RESP;
      ST_RESP: if (rsp_hs)  state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // rsp_valid is registered: it rises one edge after the capture edge so the
  // response leaves through a flop, and it drops on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      disc_img   <= '0;
      rsp_src    <= SRC_REAL;
      rsp_prob   <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (accept) begin
        disc_img   <= gnt_fake ? fake_pix : real_pix;
        rsp_src    <= gnt_fake ? SRC_FAKE : SRC_REAL;
        settle_cnt <= '0;
      end else if (state == ST_EVAL) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
      if (capture) begin
        rsp_prob <= clamp_q15(disc_prob);
      end
      rsp_valid <= (state == ST_RESP) && !rsp_hs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_real   <= '0;
      cnt_fake   <= '0;
      cnt_fooled <= '0;
    end else if (clr_stats) begin
      cnt_real   <= '0;
      cnt_fake   <= '0;
      cnt_fooled <= '0;
    end else if (rsp_hs) begin
      if (rsp_src == SRC_FAKE) begin
        if (cnt_fake != 16'hFFFF) cnt_fake <= cnt_fake + 16'd1;
        if (rsp_is_real && (cnt_fooled != 16'hFFFF)) cnt_fooled <= cnt_fooled + 16'd1;
      end else begin
        if (cnt_real != 16'hFFFF) cnt_real <= cnt_real + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_disc_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_disc_scheduler
// Description : Self-checking bench for disc_scheduler. A transaction-level
//               model (edges since accept, round-robin memory, saturating
//               counters) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disc_scheduler;

  localparam int S = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          real_valid, fake_valid, rsp_ready, clr_stats;
  logic [143:0]  real_pix, fake_pix;
  logic          real_ready, fake_ready, rsp_valid, rsp_src, rsp_is_real;
  logic [143:0]  disc_img;
  logic [15:0]   disc_prob, rsp_prob, cnt_real, cnt_fake, cnt_fooled;
  logic [15:0]   prob_ofs;

  int n_checks = 0;
  int n_errors = 0;

  // Discriminator stand-in: pixel 0 plus a bench-controlled offset.
  assign disc_prob = disc_img[15:0] + prob_ofs;

  always #5 clk = ~clk;

  disc_scheduler #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .real_valid(real_valid), .real_ready(real_ready), .real_pix(real_pix),
    .fake_valid(fake_valid), .fake_ready(fake_ready), .fake_pix(fake_pix),
    .disc_img(disc_img), .disc_prob(disc_prob),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prob(rsp_prob),
    .rsp_src(rsp_src), .rsp_is_real(rsp_is_real), .clr_stats(clr_stats),
    .cnt_real(cnt_real), .cnt_fake(cnt_fake), .cnt_fooled(cnt_fooled)
  );

  // Reference model state
  bit           m_busy;
  int           m_t;        // edges since the accept edge
  logic         m_last;     // source granted most recently
  logic         m_src;
  logic [143:0] m_img;
  logic [15:0]  m_prob;
  logic [15:0]  m_cr, m_cf, m_fo;
  logic         acc_q[$];

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [143:0] rnd_pix();
    logic [143:0] v;
    for (int i = 0; i < 9; i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_last = 1'b1; m_src = 1'b0;
    m_img = '0; m_prob = '0; m_cr = '0; m_cf = '0; m_fo = '0;
  endtask

  function automatic bit model_rsp_valid();
    return m_busy && (m_t >= S + 1);
  endfunction

  // One cycle: drive at negedge, check, advance the model across the posedge.
  task automatic step(input logic rv, input logic fv, input logic [143:0] rp,
                      input logic [143:0] fp, input logic rr, input logic clr);
    logic exp_gr, exp_gf, exp_v, hs;
    real_valid = rv; fake_valid = fv; real_pix = rp; fake_pix = fp;
    rsp_ready = rr; clr_stats = clr;
    #1;
    exp_gr = 1'b0; exp_gf = 1'b0;
    if (!m_busy) begin
      exp_gr = rv && (!fv || m_last == 1'b1);
      exp_gf = fv && (!rv || m_last == 1'b0);
    end
    exp_v = model_rsp_valid();
    chk("real_ready", 144'(real_ready), 144'(exp_gr));
    chk("fake_ready", 144'(fake_ready), 144'(exp_gf));
    chk("rsp_valid", 144'(rsp_valid), 144'(exp_v));
    if (exp_v) begin
      chk("rsp_prob", 144'(rsp_prob), 144'(m_prob));
      chk("rsp_src", 144'(rsp_src), 144'(m_src));
      chk("rsp_is_real", 144'(rsp_is_real), 144'(m_prob >= 16'h4000));
    end
    chk("disc_img", disc_img, m_img);
    chk("cnt_real", 144'(cnt_real), 144'(m_cr));
    chk("cnt_fake", 144'(cnt_fake), 144'(m_cf));
    chk("cnt_fooled", 144'(cnt_fooled), 144'(m_fo));
    hs = exp_v && rr;
    if (clr) begin
      m_cr = '0; m_cf = '0; m_fo = '0;
    end else if (hs) begin
      if (m_src) begin
        m_cf = sat_inc(m_cf);
        if (m_prob >= 16'h4000) m_fo = sat_inc(m_fo);
      end else begin
        m_cr = sat_inc(m_cr);
      end
    end
    if (m_busy) begin
      if (m_t == S - 1) begin
        m_prob = m_img[15:0] + prob_ofs;
        if (m_prob[15]) m_prob = 16'h0000;
      end
      if (hs) m_busy = 0;
      else    m_t++;
    end else if (exp_gr || exp_gf) begin
      m_busy = 1; m_t = 0; m_src = exp_gf;
      m_img = exp_gf ? fp : rp; m_last = exp_gf;
      acc_q.push_back(exp_gf);
    end
    @(negedge clk);
  endtask

  task automatic finish_txn(input logic clr_at_hs);
    for (int i = 0; i < 20; i++) begin
      if (model_rsp_valid()) break;
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, clr_at_hs);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; real_valid = 1'b1; fake_valid = 1'b1; rsp_ready = 1'b1; clr_stats = 1'b0;
    #1;
    chk("rst_real_ready", 144'(real_ready), 144'(0));
    chk("rst_fake_ready", 144'(fake_ready), 144'(0));
    chk("rst_rsp_valid", 144'(rsp_valid), 144'(0));
    chk("rst_rsp_prob", 144'(rsp_prob), 144'(0));
    chk("rst_rsp_src", 144'(rsp_src), 144'(0));
    chk("rst_is_real", 144'(rsp_is_real), 144'(0));
    chk("rst_disc_img", disc_img, 144'(0));
    chk("rst_cnts", {cnt_real, cnt_fake, cnt_fooled}, 144'(0));
    @(negedge clk);
    rst_n = 1'b1; real_valid = 1'b0; fake_valid = 1'b0;
    model_reset();
  endtask

  task automatic preload_fake_ffff();
    force dut.cnt_fake = 16'hFFFF;
    #1;
    release dut.cnt_fake;
    m_cf = 16'hFFFF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] p;
    rst_n = 1'b0; real_valid = 0; fake_valid = 0; rsp_ready = 0; clr_stats = 0;
    real_pix = '0; fake_pix = '0; prob_ofs = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Single real request: all pixels 0x2000, discriminator yields 0x5000.
    prob_ofs = 16'h3000;
    step(1'b1, 1'b0, {9{16'h2000}}, '0, 1'b1, 1'b0);
    finish_txn(1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("single_cnt_real", 144'(cnt_real), 144'(1));

    // Continuous contention: alternating grants starting with real.
    do_reset();
    prob_ofs = 16'h0000;
    acc_q.delete();
    for (int i = 0; i < 4 * (S + 3); i++) step(1'b1, 1'b1, rnd_pix(), rnd_pix(), 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("rr_count", 144'(acc_q.size()), 144'(4));
    for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("rr_order", 144'(acc_q[i]), 144'(i % 2));
    chk("rr_cnt_real", 144'(cnt_real), 144'(2));
    chk("rr_cnt_fake", 144'(cnt_fake), 144'(2));

    // Negative probability clamps to zero; threshold boundaries for fooled.
    p = '0; p[15:0] = 16'h8001;
    step(1'b0, 1'b1, '0, p, 1'b0, 1'b0);
    finish_txn(1'b0);
    chk("clamp_fooled", 144'(cnt_fooled), 144'(0));
    p[15:0] = 16'h3FFF;
    step(1'b0, 1'b1, '0, p, 1'b0, 1'b0);
    finish_txn(1'b0);
    chk("below_half_fooled", 144'(cnt_fooled), 144'(0));
    p[15:0] = 16'h4000;
    step(1'b0, 1'b1, '0, p, 1'b0, 1'b0);
    finish_txn(1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("at_half_fooled", 144'(cnt_fooled), 144'(1));

    // Back-pressure: response held while both requesters keep asking.
    step(1'b1, 1'b1, rnd_pix(), rnd_pix(), 1'b0, 1'b0);
    for (int i = 0; i < 20 && !model_rsp_valid(); i++)
      step(1'b1, 1'b1, rnd_pix(), rnd_pix(), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, rnd_pix(), rnd_pix(), 1'b0, 1'b0);
    step(1'b1, 1'b1, rnd_pix(), rnd_pix(), 1'b1, 1'b0);
    step(1'b1, 1'b1, rnd_pix(), rnd_pix(), 1'b0, 1'b0);
    finish_txn(1'b0);

    // Reset during evaluation drops the request; real wins next contention.
    step(1'b0, 1'b1, '0, rnd_pix(), 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    do_reset();
    acc_q.delete();
    step(1'b1, 1'b1, rnd_pix(), rnd_pix(), 1'b1, 1'b0);
    chk("post_rst_grant", 144'(acc_q.size() > 0 ? acc_q[0] : 1'bx), 144'(0));
    finish_txn(1'b0);

    // Saturation and clear priority.
    do_reset();
    step(1'b0, 1'b1, '0, rnd_pix(), 1'b0, 1'b0);
    preload_fake_ffff();
    finish_txn(1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("clr_wins_fake", 144'(cnt_fake), 144'(0));
    step(1'b0, 1'b1, '0, rnd_pix(), 1'b0, 1'b0);
    preload_fake_ffff();
    finish_txn(1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("sat_fake", 144'(cnt_fake), 144'(16'hFFFF));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) prob_ofs = 16'($urandom);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_pix(), rnd_pix(),
           1'(($urandom % 4) != 0), 1'(($urandom % 32) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
